// File: rtl/sd_cmd_rx.sv
// SD CMD line response receiver: deserialises 48/136-bit frames, checks CRC7 and framing.
// Optional NCR timeout counter is built only when SD_CMD_RX_TIMEOUT_EN is defined.
module sd_cmd_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_en,
  input  logic         cmd_in,
  input  logic         arm,
  input  logic         resp_long,
  input  logic         crc_check,
  output logic         busy,
  output logic         resp_valid,
  output logic [135:0] resp,
  output logic         crc_err,
  output logic         frame_err,
  output logic         timeout
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RECV,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LEN_S   = CNT_W'(48);
  localparam logic [CNT_W-1:0] LEN_L   = CNT_W'(136);
  localparam logic [CNT_W-1:0] CRC_END_S = CNT_W'(40);
  localparam logic [CNT_W-1:0] CRC_BEG_L = CNT_W'(9);
  localparam logic [CNT_W-1:0] CRC_END_L = CNT_W'(128);

  if ((CNT_W < 8) || (TIMEOUT_CYCLES >= (1 << CNT_W))) begin : g_cfg_err
    $error("sd_cmd_rx: CNT_W too narrow for frame length or TIMEOUT_CYCLES");
  end

  state_t           state;
  state_t           state_nxt;
  logic             long_q;
  logic             chk_q;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_nxt;
  logic [CNT_W-1:0] frame_len;
  logic [6:0]       crc_q;
  logic [6:0]       crc_base;
  logic             crc_cover;
  logic             tx_bit;
  logic             to_hit;

  function automatic logic [6:0] crc7_step(input logic [6:0] c,
                                           input logic       d);
    logic fb;
    fb = c[6] ^ d;
    return {c[5], c[4], c[3], c[2] ^ fb, c[1], c[0], fb};
  endfunction

  assign bit_nxt   = bit_cnt + 1'b1;
  assign frame_len = long_q ? LEN_L : LEN_S;
  assign tx_bit    = long_q ? resp[134] : resp[46];

  // Long frames restart the CRC after the 8-bit header
  assign crc_base  = (long_q && bit_nxt == CRC_BEG_L) ? 7'd0 : crc_q;
  assign crc_cover = long_q ? (bit_nxt >= CRC_BEG_L && bit_nxt <= CRC_END_L)
                            : (bit_nxt <= CRC_END_S);

`ifdef SD_CMD_RX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == IDLE && arm) begin
      to_cnt <= '0;
    end else if (state == WAIT_START && sample_en && cmd_in) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = sample_en && cmd_in && (to_cnt == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    resp_valid = 1'b0;
    crc_err    = 1'b0;
    frame_err  = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE: begin
        if (arm) state_nxt = WAIT_START;
      end
      WAIT_START: begin
        busy = 1'b1;
        if (sample_en && !cmd_in) begin
          state_nxt = RECV;
        end else if (to_hit) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RECV: begin
        busy = 1'b1;
        if (sample_en && bit_nxt == frame_len) state_nxt = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        crc_err    = chk_q && (resp[7:1] != crc_q);
        frame_err  = tx_bit || !resp[0];
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      long_q  <= 1'b0;
      chk_q   <= 1'b0;
      bit_cnt <= '0;
      crc_q   <= '0;
      resp    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm) begin
            long_q  <= resp_long;
            chk_q   <= crc_check;
            bit_cnt <= '0;
            crc_q   <= '0;
            resp    <= '0;
          end
        end
        WAIT_START: begin
          if (sample_en && !cmd_in) begin
            resp    <= {resp[134:0], 1'b0};
            bit_cnt <= CNT_W'(1);
            crc_q   <= crc7_step(7'd0, 1'b0);
          end
        end
        RECV: begin
          if (sample_en) begin
            resp    <= {resp[134:0], cmd_in};
            bit_cnt <= bit_nxt;
            if (crc_cover) crc_q <= crc7_step(crc_base, cmd_in);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_rx.sv
// Directed testbench for sd_cmd_rx: good/bad short and long frames,
// R3 without CRC, NCR timeout (or its absence) and reset abort.
module tb_sd_cmd_rx;

  logic         clk = 1'b0;
  logic         rst;
  logic         sample_en;
  logic         cmd_in;
  logic         arm;
  logic         resp_long;
  logic         crc_check;
  logic         busy;
  logic         resp_valid;
  logic [135:0] resp;
  logic         crc_err;
  logic         frame_err;
  logic         timeout;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int strobe_cyc = 0;

  int           n_rv  = 0;
  int           rv_cyc = 0;
  logic [135:0] rv_resp;
  logic         rv_crc;
  logic         rv_frm;
  int           n_to  = 0;
  int           to_cyc = 0;

  logic [119:0] cid;
  logic [135:0] r2;

  sd_cmd_rx dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .cmd_in     (cmd_in),
    .arm        (arm),
    .resp_long  (resp_long),
    .crc_check  (crc_check),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp       (resp),
    .crc_err    (crc_err),
    .frame_err  (frame_err),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resp_valid) begin
      n_rv    = n_rv + 1;
      rv_cyc  = cyc;
      rv_resp = resp;
      rv_crc  = crc_err;
      rv_frm  = frame_err;
    end
    if (timeout) begin
      n_to   = n_to + 1;
      to_cyc = cyc;
    end
  end

  task automatic chk(input string tag,
                     input logic [135:0] got,
                     input logic [135:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [135:0] v, input int nbits);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = nbits - 1; i >= 0; i--) begin
      fb = c[6] ^ v[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  task automatic do_arm(input logic lng, input logic cc);
    arm = 1'b1; resp_long = lng; crc_check = cc;
    @(posedge clk); #1;
    arm = 1'b0; resp_long = ~lng; crc_check = ~cc;
  endtask

  task automatic send_bit(input logic b);
    sample_en = 1'b1; cmd_in = b;
    @(posedge clk); #1;
    strobe_cyc = cyc;
    sample_en  = 1'b0; cmd_in = ~b;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input string tag, input logic [135:0] f,
                           input logic lng, input logic cc,
                           input logic ecrc, input logic efrm,
                           input int arm_at);
    int rv0;
    int len;
    rv0 = n_rv;
    len = lng ? 136 : 48;
    do_arm(lng, cc);
    chk({tag, "_busy"}, 136'(busy), 136'(1));
    repeat (5) send_bit(1'b1);
    for (int i = len - 1; i >= 0; i--) begin
      send_bit(f[i]);
      if (i == arm_at) do_arm(~lng, ~cc);
    end
    chk({tag, "_nvalid"}, 136'(n_rv - rv0), 136'(1));
    chk({tag, "_lat"}, 136'(rv_cyc), 136'(strobe_cyc));
    chk({tag, "_resp"}, rv_resp, f);
    chk({tag, "_crc"}, 136'(rv_crc), 136'(ecrc));
    chk({tag, "_frm"}, 136'(rv_frm), 136'(efrm));
    chk({tag, "_idle"}, 136'(busy), 136'(0));
  endtask

  initial begin
    int rv0;
    int to0;
    rst = 1'b1; sample_en = 1'b0; cmd_in = 1'b1;
    arm = 1'b0; resp_long = 1'b0; crc_check = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 136'(busy), 136'(0));
    chk("rst_valid", 136'(resp_valid), 136'(0));
    chk("rst_resp", resp, 136'(0));
    chk("rst_flags", 136'({crc_err, frame_err, timeout}), 136'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame("r7", 136'h08000001AA13, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    run_frame("r7crc", 136'h08000001AA15, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    run_frame("r7end", 136'h08000001AA12, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    run_frame("r3", 136'h3F80FF8000FF, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    cid = 120'h035344534433324780123456780_12A;
    r2  = {8'h3F, cid, crc7({16'h0, cid}, 120), 1'b1};
    run_frame("r2", r2, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    r2[100] = ~r2[100];
    run_frame("r2flip", r2, 1'b1, 1'b1, 1'b1, 1'b0, -1);

    rv0 = n_rv;
    to0 = n_to;
    do_arm(1'b0, 1'b1);
`ifdef SD_CMD_RX_TIMEOUT_EN
    repeat (63) send_bit(1'b1);
    chk("to_early", 136'(n_to - to0), 136'(0));
    chk("to_busy", 136'(busy), 136'(1));
    send_bit(1'b1);
    chk("to_pulse", 136'(n_to - to0), 136'(1));
    chk("to_cyc", 136'(to_cyc), 136'(strobe_cyc - 1));
    chk("to_idle", 136'(busy), 136'(0));
    chk("to_novalid", 136'(n_rv - rv0), 136'(0));
`else
    repeat (200) send_bit(1'b1);
    chk("nto_busy", 136'(busy), 136'(1));
    chk("nto_pulse", 136'(n_to - to0), 136'(0));
    chk("nto_novalid", 136'(n_rv - rv0), 136'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("nto_rst", 136'(busy), 136'(0));
`endif

    rv0 = n_rv;
    do_arm(1'b0, 1'b1);
    repeat (3) send_bit(1'b1);
    for (int i = 47; i >= 28; i--) send_bit(r2[i]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 136'(busy), 136'(0));
    chk("abort_resp", resp, 136'(0));
    repeat (10) @(posedge clk);
    #1;
    chk("abort_novalid", 136'(n_rv - rv0), 136'(0));
    run_frame("rearm", 136'h08000001AA13, 1'b0, 1'b1, 1'b0, 1'b0, 30);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
